adda_trig_seq: RTL

Parametrised successor to the single-channel VIO trigger register. It takes the raw VIO SYNC_OUT word, which is already synchronous to clk, and holds ch_num independent address/data trigger words plus a page-count value. A host-toggled apply bit commits a new configuration atomically. The block compares a bus-tap stream against the enabled channels, counts hits, and declares done after pnum qualifying hit cycles; it sits between the VIO core and the bus-tap capture logic.

---
 rtl/adda_trig_seq.sv | 83 ++++++++
 1 files changed

// File: rtl/adda_trig_seq.sv
// adda_trig_seq: VIO-driven multi-channel address/data trigger with atomic commit and hit counting
module adda_trig_seq #(
  parameter int trig_width = 56,
  parameter int pnum_width = 10,
  parameter int ch_num     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ch_num*(trig_width+1)+pnum_width:0] vio_in,
  input  logic                             tap_valid,
  input  logic [trig_width-1:0]            tap_word,
  output logic [ch_num*trig_width-1:0]     trig_out,
  output logic [pnum_width-1:0]            pnum_out,
  output logic [ch_num-1:0]                ch_en,
  output logic                             cfg_upd,
  output logic                             armed,
  output logic [ch_num-1:0]                trig_hit,
  output logic [pnum_width-1:0]            hit_cnt,
  output logic                             trig_done
);
  localparam int vw = 1 + ch_num + pnum_width + ch_num * trig_width;
  localparam int tw = ch_num * trig_width;
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state, state_n;
  logic [vw-1:0] vio_q;
  logic apply_prev, primed, commit, any_hit, reach;
  logic [ch_num-1:0] hit;
  logic [pnum_width-1:0] cnt_inc;
  assign commit  = primed && (vio_q[vw-1] != apply_prev);
  assign any_hit = |hit;
  assign cnt_inc = hit_cnt + 1'b1;
  assign reach   = (state == ARMED) && any_hit && (pnum_out != '0) && (cnt_inc == pnum_out);
  // per-channel comparison of the tap sample against the committed words
  always_comb begin
    hit = '0;
    for (int i = 0; i < ch_num; i++)
      hit[i] = tap_valid & ch_en[i] & (tap_word == trig_out[i*trig_width +: trig_width]);
  end
  // next state: a commit always restarts, otherwise ARMED finishes on the last page hit
  always_comb state_n = commit ? ARMED : reach ? DONE : state;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // input stage; priming seeds apply_prev from the live word so a held apply bit never commits
  always_ff @(posedge clk)
    if (rst) begin
      vio_q      <= '0;
      apply_prev <= 1'b0;
      primed     <= 1'b0;
    end else begin
      vio_q      <= vio_in;
      primed     <= 1'b1;
      apply_prev <= primed ? vio_q[vw-1] : vio_in[vw-1];
    end
  // committed configuration, hit tracking and status outputs; commit beats a coincident hit
  always_ff @(posedge clk)
    if (rst) begin
      trig_out  <= '0;
      pnum_out  <= '0;
      ch_en     <= '0;
      cfg_upd   <= 1'b0;
      armed     <= 1'b0;
      trig_hit  <= '0;
      hit_cnt   <= '0;
      trig_done <= 1'b0;
    end else begin
      cfg_upd <= commit;
      armed   <= (state_n == ARMED);
      if (commit) begin
        trig_out  <= vio_q[tw-1:0];
        pnum_out  <= vio_q[tw +: pnum_width];
        ch_en     <= vio_q[tw+pnum_width +: ch_num];
        hit_cnt   <= '0;
        trig_done <= 1'b0;
        trig_hit  <= '0;
      end else if (state == ARMED) begin
        trig_hit <= hit;
        if (any_hit && !(&hit_cnt)) hit_cnt <= cnt_inc;
        if (reach) trig_done <= 1'b1;
      end else trig_hit <= '0;
    end
endmodule
